imem_loader: RTL and testbench

//  Host-side writer for the instruction RAM that the pipeline fetches from (read-only at the core).

---
 rtl/imem_loader_pkg.sv | 32 +++
 rtl/ldr_timeout_ctr.sv | 27 ++
 rtl/imem_loader.sv | 148 ++++++++++++++
 tb/tb_imem_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-RAM loader: FSM state encodings and sticky
// error codes, also decoded by the display/debug logic.
package imem_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_W_HI,
        ST_W_LO,
        ST_WRITE,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } ldr_state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CHK  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    // States in which a stream byte may be taken (and the inter-byte timer runs).
    function automatic logic isRxState(input ldr_state_t s);
        return (s inside {ST_LEN_HI, ST_LEN_LO, ST_W_HI, ST_W_LO, ST_CHK});
    endfunction

    // Resting states: the only ones where a start pulse re-arms the loader.
    function automatic logic isArmable(input ldr_state_t s);
        return (s inside {ST_IDLE, ST_DONE, ST_ERR});
    endfunction

endpackage

// File: rtl/ldr_timeout_ctr.sv
// Inter-byte watchdog: reloads on clear, counts down while enabled, and flags
// expiry on the enabled cycle that would exhaust the TIMEOUT budget.
module ldr_timeout_ctr #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= CW'(TIMEOUT);
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expire = i_enable && (r_count == CW'(1));

endmodule

// File: rtl/imem_loader.sv
// Host-side instruction-RAM writer: parses a length/words/checksum byte frame,
// writes consecutive 16-bit words from address 0 and stalls the core until verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 256,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              mem_wren,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [ADDR_W-1:0] words
);

    ldr_state_t        r_state;
    logic [15:0]       r_len;
    logic [7:0]        r_hi;
    logic [7:0]        r_sum;
    logic [ADDR_W-1:0] r_words;
    logic [ADDR_W-1:0] r_memAddr;
    logic [15:0]       r_memData;
    logic              r_memWren;
    logic              r_cpuHold;
    logic              r_done;
    logic [1:0]        r_err;

    logic              w_accept;
    logic              w_start;
    logic              w_expire;
    logic [15:0]       w_lenNext;
    logic [ADDR_W-1:0] w_wordsInc;

    assign rx_ready   = isRxState(r_state);
    assign busy       = !isArmable(r_state);
    assign w_accept   = rx_valid && rx_ready;
    assign w_start    = start && isArmable(r_state);
    assign w_lenNext  = {r_len[15:8], rx_data};
    assign w_wordsInc = r_words + 1'b1;

    ldr_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_accept || w_start),
        .i_enable (rx_ready && !w_accept),
        .o_expire (w_expire)
    );

    // Expiry and byte acceptance are mutually exclusive, since the timer only runs on idle rx cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_len     <= '0;
            r_hi      <= '0;
            r_sum     <= '0;
            r_words   <= '0;
            r_memAddr <= '0;
            r_memData <= '0;
            r_memWren <= 1'b0;
            r_cpuHold <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= ERR_NONE;
        end else begin
            r_memWren <= 1'b0;
            if (w_start) begin
                r_state   <= ST_LEN_HI;
                r_done    <= 1'b0;
                r_err     <= ERR_NONE;
                r_words   <= '0;
                r_sum     <= '0;
                r_cpuHold <= 1'b1;
            end else if (w_expire) begin
                r_state <= ST_ERR;
                r_err   <= ERR_TMO;
            end else begin
                case (r_state)
                    ST_LEN_HI: if (w_accept) begin
                        r_len[15:8] <= rx_data;
                        r_sum       <= r_sum + rx_data;
                        r_state     <= ST_LEN_LO;
                    end
                    ST_LEN_LO: if (w_accept) begin
                        r_len[7:0] <= rx_data;
                        r_sum      <= r_sum + rx_data;
                        if (w_lenNext == 16'd0) begin
                            r_state <= ST_CHK;
                        end else if ({1'b0, w_lenNext} > 17'(DEPTH)) begin
                            r_state <= ST_ERR;
                            r_err   <= ERR_LEN;
                        end else begin
                            r_state <= ST_W_HI;
                        end
                    end
                    ST_W_HI: if (w_accept) begin
                        r_hi    <= rx_data;
                        r_sum   <= r_sum + rx_data;
                        r_state <= ST_W_LO;
                    end
                    ST_W_LO: if (w_accept) begin
                        r_sum     <= r_sum + rx_data;
                        r_memData <= {r_hi, rx_data};
                        r_memAddr <= r_words;
                        r_memWren <= 1'b1;
                        r_state   <= ST_WRITE;
                    end
                    ST_WRITE: begin
                        if (r_words != ADDR_W'(DEPTH)) begin
                            r_words <= w_wordsInc;
                        end
                        r_state <= (w_wordsInc == ADDR_W'(r_len)) ? ST_CHK : ST_W_HI;
                    end
                    ST_CHK: if (w_accept) begin
                        if (rx_data == r_sum) begin
                            r_state   <= ST_DONE;
                            r_done    <= 1'b1;
                            r_cpuHold <= 1'b0;
                        end else begin
                            r_state <= ST_ERR;
                            r_err   <= ERR_CHK;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_addr = r_memAddr;
    assign mem_data = r_memData;
    assign mem_wren = r_memWren;
    assign cpu_hold = r_cpuHold;
    assign done     = r_done;
    assign err      = r_err;
    assign words    = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of whole frames plus hand-written sequences for
// start/byte collision, write latency, inter-byte timeout and mid-frame reset.
module tb_imem_loader;

    localparam int ADDR_W  = 16;
    localparam int DEPTH   = 256;
    localparam int TIMEOUT = 16;
    localparam int NVEC    = 5;

    typedef struct {
        string      name;
        logic [7:0] bytes [0:9];
        int         nBytes;
        logic       expDone;
        logic [1:0] expErr;
        int         expWords;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    logic              mem_wren;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic [1:0]        err;
    logic [ADDR_W-1:0] words;

    int   errorCount = 0;
    int   checkCount = 0;
    int   acceptCount = 0;
    int   writeCount = 0;
    logic [15:0] ramSeen [0:DEPTH-1];
    vec_t vecs [NVEC];

    imem_loader #(
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_wren (mem_wren),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .words    (words)
    );

    always #5 clk = ~clk;

    // Monitor of the RAM write port and of the byte handshake.
    always @(posedge clk) begin
        if (rx_valid && rx_ready) acceptCount++;
        if (mem_wren) begin
            ramSeen[mem_addr[7:0]] = mem_data;
            writeCount++;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "/rx_ready"}, 32'(rx_ready), 0);
        checkOutput({tag, "/mem_wren"}, 32'(mem_wren), 0);
        checkOutput({tag, "/mem_addr"}, 32'(mem_addr), 0);
        checkOutput({tag, "/mem_data"}, 32'(mem_data), 0);
        checkOutput({tag, "/cpu_hold"}, 32'(cpu_hold), 0);
        checkOutput({tag, "/busy"},     32'(busy),     0);
        checkOutput({tag, "/done"},     32'(done),     0);
        checkOutput({tag, "/err"},      32'(err),      0);
        checkOutput({tag, "/words"},    32'(words),    0);
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers one byte after a random gap; returns on the negedge after it is taken.
    task automatic sendByte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        for (int k = 0; k < 40 && !got; k++) begin
            if (rx_ready) got = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        checkOutput("byte accepted", 32'(got), 1);
    endtask

    task automatic sendBytesOf(input int idx);
        for (int i = 0; i < vecs[idx].nBytes; i++) sendByte(vecs[idx].bytes[i]);
    endtask

    task automatic checkResult(input int idx, input int baseAcc, input int baseWr);
        string n;
        n = vecs[idx].name;
        repeat (2) @(negedge clk);
        checkOutput({n, "/done"},     32'(done),     32'(vecs[idx].expDone));
        checkOutput({n, "/err"},      32'(err),      32'(vecs[idx].expErr));
        checkOutput({n, "/words"},    32'(words),    32'(vecs[idx].expWords));
        checkOutput({n, "/cpu_hold"}, 32'(cpu_hold), 32'(!vecs[idx].expDone));
        checkOutput({n, "/busy"},     32'(busy),     0);
        checkOutput({n, "/rx_ready"}, 32'(rx_ready), 0);
        checkOutput({n, "/accepted"}, 32'(acceptCount - baseAcc), 32'(vecs[idx].nBytes));
        checkOutput({n, "/writes"},   32'(writeCount - baseWr),   32'(vecs[idx].expWords));
        for (int i = 0; i < vecs[idx].expWords; i++) begin
            checkOutput($sformatf("%s/ram[%0d]", n, i), 32'(ramSeen[i]),
                        32'({vecs[idx].bytes[2 + 2*i], vecs[idx].bytes[3 + 2*i]}));
        end
    endtask

    task automatic applyStimulus(input int idx);
        int baseAcc;
        int baseWr;
        baseAcc = acceptCount;
        baseWr  = writeCount;
        pulseStart();
        checkOutput({vecs[idx].name, "/hold_on_start"}, 32'(cpu_hold), 1);
        checkOutput({vecs[idx].name, "/busy_on_start"}, 32'(busy), 1);
        sendBytesOf(idx);
        checkResult(idx, baseAcc, baseWr);
    endtask

    initial begin
        int baseAcc;
        int baseWr;

        vecs[0].name = "two_words";
        vecs[0].bytes = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0, 8'h00, 8'h00, 8'h00};
        vecs[0].nBytes = 7; vecs[0].expDone = 1'b1; vecs[0].expErr = 2'd0; vecs[0].expWords = 2;

        vecs[1].name = "empty";
        vecs[1].bytes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1].nBytes = 3; vecs[1].expDone = 1'b1; vecs[1].expErr = 2'd0; vecs[1].expWords = 0;

        vecs[2].name = "bad_chk";
        vecs[2].bytes = '{8'h00, 8'h01, 8'h00, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2].nBytes = 5; vecs[2].expDone = 1'b0; vecs[2].expErr = 2'd2; vecs[2].expWords = 1;

        vecs[3].name = "too_long";
        vecs[3].bytes = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3].nBytes = 2; vecs[3].expDone = 1'b0; vecs[3].expErr = 2'd1; vecs[3].expWords = 0;

        vecs[4].name = "three_words";
        vecs[4].bytes = '{8'h00, 8'h03, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h80, 8'h01, 8'h82, 8'h00};
        vecs[4].nBytes = 9; vecs[4].expDone = 1'b1; vecs[4].expErr = 2'd0; vecs[4].expWords = 3;

        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);

        // A byte presented together with start in IDLE must not be consumed.
        baseAcc = acceptCount;
        baseWr  = writeCount;
        start = 1'b1; rx_valid = 1'b1; rx_data = 8'h5A;
        checkOutput("collide/rx_ready_idle", 32'(rx_ready), 0);
        @(negedge clk);
        start = 1'b0; rx_valid = 1'b0;
        checkOutput("collide/no_accept", 32'(acceptCount - baseAcc), 0);
        checkOutput("collide/rx_ready_len", 32'(rx_ready), 1);
        sendBytesOf(0);
        checkResult(0, baseAcc, baseWr);

        for (int v = 0; v < NVEC; v++) applyStimulus(v);

        // Write strobe appears one cycle after the low byte, word count steps after it.
        pulseStart();
        sendByte(8'h00);
        sendByte(8'h01);
        sendByte(8'hAB);
        sendByte(8'hCD);
        checkOutput("latency/wren",     32'(mem_wren), 1);
        checkOutput("latency/addr",     32'(mem_addr), 0);
        checkOutput("latency/data",     32'(mem_data), 32'h0000ABCD);
        checkOutput("latency/words0",   32'(words),    0);
        checkOutput("latency/rx_ready", 32'(rx_ready), 0);
        @(negedge clk);
        checkOutput("latency/wren_off", 32'(mem_wren), 0);
        checkOutput("latency/words1",   32'(words),    1);
        sendByte(8'h79);
        @(negedge clk);
        checkOutput("latency/done", 32'(done), 1);

        // Stall mid-word: error must appear exactly on the TIMEOUT-th idle cycle.
        pulseStart();
        sendByte(8'h00);
        sendByte(8'h01);
        sendByte(8'h12);
        repeat (TIMEOUT - 1) @(negedge clk);
        checkOutput("timeout/err_before", 32'(err),  0);
        checkOutput("timeout/busy",       32'(busy), 1);
        @(negedge clk);
        checkOutput("timeout/err",      32'(err),      3);
        checkOutput("timeout/cpu_hold", 32'(cpu_hold), 1);
        checkOutput("timeout/rx_ready", 32'(rx_ready), 0);
        applyStimulus(0);

        // Reset in the middle of a frame, then a clean reload.
        pulseStart();
        sendByte(8'h00);
        sendByte(8'h02);
        sendByte(8'h12);
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("midreset");
        rst = 1'b0;
        applyStimulus(0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
